window_op_controller: RTL and testbench

WINDOW_OP_CONTROLLER -- requirements
Module: window_op_controller

---
 rtl/window_op_controller.sv | 125 ++++++++++++
 tb/tb_window_op_controller.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/window_op_controller.sv
// Register-window operation sequencer: SAVE/RESTORE with window-overflow/underflow
// trap checks against WIM, plus single-cycle CALL and RDCWP operand steering.
module window_op_controller #(
    parameter int NWINDOWS = 8
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Start,
    input  logic [1:0]  Op,
    input  logic [4:0]  CWP,
    input  logic [31:0] WIM,
    output logic [1:0]  MUX_A,
    output logic        Latch_Result,
    output logic        Load_CWP,
    output logic [4:0]  New_CWP,
    output logic        RF_Write,
    output logic        Busy,
    output logic        Done,
    output logic        Trap,
    output logic [1:0]  Trap_Type
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CHECK   = 3'd1,
        OPERAND = 3'd2,
        COMMIT  = 3'd3,
        WRITE   = 3'd4,
        EXEC    = 3'd5,
        TRAP    = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        OP_SAVE    = 2'b00,
        OP_RESTORE = 2'b01,
        OP_CALL    = 2'b10,
        OP_RDCWP   = 2'b11
    } op_t;

    localparam logic [4:0] LAST = 5'(NWINDOWS - 1);

    state_t     state;
    op_t        op_q;
    logic [4:0] cwp_q;
    logic [4:0] next_cwp;
    logic       wim_hit;

    // Out-of-range latched CWP values are folded onto the legal window range.
    always_comb begin
        next_cwp = cwp_q;
        if (op_q == OP_SAVE) begin
            next_cwp = (cwp_q == '0 || cwp_q > LAST) ? LAST : cwp_q - 5'd1;
        end else if (op_q == OP_RESTORE) begin
            next_cwp = (cwp_q >= LAST) ? '0 : cwp_q + 5'd1;
        end
        wim_hit = WIM[next_cwp];
    end

    assign Busy = (state != IDLE);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state        <= IDLE;
            op_q         <= OP_SAVE;
            cwp_q        <= '0;
            MUX_A        <= 2'b00;
            Latch_Result <= 1'b0;
            Load_CWP     <= 1'b0;
            New_CWP      <= '0;
            RF_Write     <= 1'b0;
            Done         <= 1'b0;
            Trap         <= 1'b0;
            Trap_Type    <= 2'b00;
        end else begin
            // Outputs are registered for the state being entered.
            MUX_A        <= 2'b00;
            Latch_Result <= 1'b0;
            Load_CWP     <= 1'b0;
            RF_Write     <= 1'b0;
            Done         <= 1'b0;
            Trap         <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        op_q      <= op_t'(Op);
                        cwp_q     <= CWP;
                        Trap_Type <= 2'b00;
                        if (Op[1]) begin
                            state    <= EXEC;
                            MUX_A    <= (op_t'(Op) == OP_CALL) ? 2'b01 : 2'b10;
                            RF_Write <= 1'b1;
                            Done     <= 1'b1;
                        end else begin
                            state <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    New_CWP <= next_cwp;
                    if (wim_hit) begin
                        state     <= TRAP;
                        Trap      <= 1'b1;
                        Done      <= 1'b1;
                        Trap_Type <= (op_q == OP_SAVE) ? 2'b01 : 2'b10;
                    end else begin
                        state        <= OPERAND;
                        Latch_Result <= 1'b1;
                    end
                end
                OPERAND: begin
                    state    <= COMMIT;
                    Load_CWP <= 1'b1;
                end
                COMMIT: begin
                    state    <= WRITE;
                    RF_Write <= 1'b1;
                    Done     <= 1'b1;
                end
                WRITE, EXEC, TRAP: state <= IDLE;
                default:           state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_window_op_controller.sv
// Directed self-checking bench for window_op_controller with NWINDOWS=8.
module tb_window_op_controller;

    logic        Clk;
    logic        Reset_n;
    logic        Start;
    logic [1:0]  Op;
    logic [4:0]  CWP;
    logic [31:0] WIM;
    logic [1:0]  MUX_A;
    logic        Latch_Result;
    logic        Load_CWP;
    logic [4:0]  New_CWP;
    logic        RF_Write;
    logic        Busy;
    logic        Done;
    logic        Trap;
    logic [1:0]  Trap_Type;

    int n_checks = 0;
    int n_fail   = 0;

    window_op_controller #(.NWINDOWS(8)) dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .Start        (Start),
        .Op           (Op),
        .CWP          (CWP),
        .WIM          (WIM),
        .MUX_A        (MUX_A),
        .Latch_Result (Latch_Result),
        .Load_CWP     (Load_CWP),
        .New_CWP      (New_CWP),
        .RF_Write     (RF_Write),
        .Busy         (Busy),
        .Done         (Done),
        .Trap         (Trap),
        .Trap_Type    (Trap_Type)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    // Packs all outputs except New_CWP/Trap_Type: {MUX_A,Latch,Load,RF_Write,Busy,Done,Trap}
    function automatic logic [7:0] strobes();
        return {MUX_A, Latch_Result, Load_CWP, RF_Write, Busy, Done, Trap};
    endfunction

    task automatic launch(input logic [1:0] op, input logic [4:0] cwp, input logic [31:0] wim);
        Op = op; CWP = cwp; WIM = wim; Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    initial begin
        Reset_n = 1'b1; Start = 1'b0; Op = 2'b00; CWP = '0; WIM = '0;
        #2 Reset_n = 1'b0;
        #1;
        check("reset_strobes", 32'(strobes()), 32'h00);
        check("reset_newcwp", 32'(New_CWP), 32'd0);
        check("reset_traptype", 32'(Trap_Type), 32'd0);
        @(negedge Clk); @(negedge Clk);
        Reset_n = 1'b1;

        // SAVE, CWP=3, WIM=0; inputs changed after acceptance and Start re-pulsed while Busy
        launch(2'b00, 5'd3, 32'h0);
        check("save_c1", 32'(strobes()), 32'b00_0_0_0_1_0_0);
        CWP = 5'd6; Op = 2'b01; Start = 1'b1;
        tick();
        check("save_c2", 32'(strobes()), 32'b00_1_0_0_1_0_0);
        check("save_newcwp", 32'(New_CWP), 32'd2);
        tick();
        check("save_c3", 32'(strobes()), 32'b00_0_1_0_1_0_0);
        tick();
        check("save_c4", 32'(strobes()), 32'b00_0_0_1_1_1_0);
        Start = 1'b0;
        tick();
        check("save_idle", 32'(strobes()), 32'h00);
        tick();
        check("save_noqueue", 32'(strobes()), 32'h00);
        check("save_newcwp_hold", 32'(New_CWP), 32'd2);

        // RESTORE, CWP=7 wraps to 0, WIM bit 0 set -> underflow
        launch(2'b01, 5'd7, 32'h01);
        check("rest_c1", 32'(strobes()), 32'b00_0_0_0_1_0_0);
        tick();
        check("rest_trap", 32'(strobes()), 32'b00_0_0_0_1_1_1);
        check("rest_traptype", 32'(Trap_Type), 32'd2);
        check("rest_newcwp", 32'(New_CWP), 32'd0);
        tick();
        check("rest_idle", 32'(strobes()), 32'h00);
        check("rest_traptype_hold", 32'(Trap_Type), 32'd2);

        // SAVE, CWP=0 wraps to 7, WIM bit 7 set -> overflow
        launch(2'b00, 5'd0, 32'h80);
        check("ovf_clear", 32'(Trap_Type), 32'd0);
        tick();
        check("ovf_trap", 32'(strobes()), 32'b00_0_0_0_1_1_1);
        check("ovf_traptype", 32'(Trap_Type), 32'd1);
        check("ovf_newcwp", 32'(New_CWP), 32'd7);
        tick();

        // Same SAVE with WIM=0 completes into window 7
        launch(2'b00, 5'd0, 32'h00);
        check("wrap_clear", 32'(Trap_Type), 32'd0);
        tick();
        check("wrap_newcwp", 32'(New_CWP), 32'd7);
        check("wrap_c2", 32'(strobes()), 32'b00_1_0_0_1_0_0);
        tick(); tick();
        check("wrap_c4", 32'(strobes()), 32'b00_0_0_1_1_1_0);
        tick();

        // RESTORE, CWP=2 -> 3, no trap; WIM bit 2 set but not the target
        launch(2'b01, 5'd2, 32'h04);
        tick();
        check("rest_ok_newcwp", 32'(New_CWP), 32'd3);
        check("rest_ok_c2", 32'(strobes()), 32'b00_1_0_0_1_0_0);
        tick(); tick(); tick();

        // CALL and RDCWP in one cycle
        launch(2'b10, 5'd5, 32'h0);
        check("call_c1", 32'(strobes()), 32'b01_0_0_1_1_1_0);
        tick();
        check("call_idle", 32'(strobes()), 32'h00);
        launch(2'b11, 5'd5, 32'h0);
        check("rdcwp_c1", 32'(strobes()), 32'b10_0_0_1_1_1_0);
        tick();
        check("rdcwp_idle", 32'(strobes()), 32'h00);

        // Reset during COMMIT, then first Start after release accepted on the first edge
        launch(2'b00, 5'd4, 32'h0);
        tick(); tick();
        check("rst_commit", 32'(strobes()), 32'b00_0_1_0_1_0_0);
        #2 Reset_n = 1'b0;
        #1;
        check("rst_async", 32'(strobes()), 32'h00);
        check("rst_async_newcwp", 32'(New_CWP), 32'd0);
        @(negedge Clk);
        Reset_n = 1'b1;
        Op = 2'b00; CWP = 5'd4; Start = 1'b1;
        tick();
        Start = 1'b0;
        check("rst_first_start", 32'(strobes()), 32'b00_0_0_0_1_0_0);
        tick(); tick(); tick();
        check("rst_resave_done", 32'(strobes()), 32'b00_0_0_1_1_1_0);
        check("rst_resave_newcwp", 32'(New_CWP), 32'd3);
        tick();
        check("final_idle", 32'(strobes()), 32'h00);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
